// File: rtl/alu_exec_unit.sv
// ALU execute unit: decodes ALUOp/Funct to a 4-bit Operation and runs it on the request
// operands behind a valid/ready handshake; MUL iterates shift-add over WIDTH cycles.
module alu_exec_unit #(
  parameter int unsigned WIDTH  = 64,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [3:0]       Funct,
  input  logic             MulExt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       Operation,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Illegal
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpSlt  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;
  localparam logic [3:0] OpMul  = 4'b1010;
  localparam logic [3:0] OpIll  = 4'b1111;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [ShW-1:0]   cnt_q, cnt_d;

  logic [3:0]       dec_op;
  logic [WIDTH-1:0] exec_res;
  logic [WIDTH-1:0] acc_sum;
  logic [ShW-1:0]   shamt;
  logic             accept;

  always_comb begin
    dec_op = OpIll;
    case (ALUOp)
      2'b00: dec_op = OpAdd;
      2'b01: dec_op = OpSub;
      2'b10: begin
        if (MulExt) begin
          if (MUL_EN && (Funct[2:0] == 3'b000)) dec_op = OpMul;
        end else begin
          case (Funct)
            4'b0000: dec_op = OpAdd;
            4'b1000: dec_op = OpSub;
            4'b0111: dec_op = OpAnd;
            4'b0110: dec_op = OpOr;
            4'b0100: dec_op = OpXor;
            4'b0001: dec_op = OpSll;
            4'b0101: dec_op = OpSrl;
            4'b1101: dec_op = OpSra;
            4'b0010: dec_op = OpSlt;
            4'b0011: dec_op = OpSltu;
            default: dec_op = OpIll;
          endcase
        end
      end
      default: begin
        // I-type: funct7 only matters to pick SRA over SRL
        case (Funct[2:0])
          3'b000:  dec_op = OpAdd;
          3'b111:  dec_op = OpAnd;
          3'b110:  dec_op = OpOr;
          3'b100:  dec_op = OpXor;
          3'b001:  dec_op = OpSll;
          3'b101:  dec_op = Funct[3] ? OpSra : OpSrl;
          3'b010:  dec_op = OpSlt;
          default: dec_op = OpSltu;
        endcase
      end
    endcase
  end

  assign shamt = B[ShW-1:0];

  always_comb begin
    exec_res = '0;
    case (dec_op)
      OpAnd:   exec_res = A & B;
      OpOr:    exec_res = A | B;
      OpAdd:   exec_res = A + B;
      OpXor:   exec_res = A ^ B;
      OpSll:   exec_res = A << shamt;
      OpSrl:   exec_res = A >> shamt;
      OpSub:   exec_res = A - B;
      OpSra:   exec_res = $unsigned($signed(A) >>> shamt);
      OpSlt:   exec_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OpSltu:  exec_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: exec_res = '0;
    endcase
  end

  assign acc_sum  = acc_q + (b_sh_q[0] ? a_sh_q : '0);
  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          op_d      = dec_op;
          illegal_d = (dec_op == OpIll);
          if (dec_op == OpMul) begin
            a_sh_d  = A;
            b_sh_d  = B;
            acc_d   = '0;
            cnt_d   = ShW'(WIDTH - 1);
            state_d = StMul;
          end else begin
            result_d = exec_res;
            state_d  = StDone;
          end
        end else if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
      end
      StMul: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = acc_sum;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      op_q      <= OpAnd;
      illegal_q <= 1'b0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign Operation = op_q;
  assign Result    = result_q;
  assign Zero      = (result_q == '0);
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: three instances (64-bit, 8-bit, 8-bit without MUL) sharing
// operand buses; a vector table plus hand-written MUL, backpressure and reset sequences.
module tb_alu_exec_unit;

  typedef struct {
    int         sel;
    logic [1:0] aluop;
    logic [3:0] funct;
    logic       mulext;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] res;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] res;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic        mulext;
  logic [63:0] a_in;
  logic [63:0] b_in;
  int          sel;

  logic        iv0, iv1, iv2;
  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [3:0]  op0, op1, op2;
  logic [63:0] res0;
  logic [7:0]  res1, res2;
  logic        z0, z1, z2;
  logic        il0, il1, il2;

  logic        c_ir, c_ov, c_z, c_il;
  logic [3:0]  c_op;
  logic [63:0] c_res;

  int   total;
  int   passed;
  exp_t exp_q[$];
  vec_t vecs[$];

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  alu_exec_unit #(.WIDTH(64), .MUL_EN(1'b1)) dut64 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .ALUOp(aluop), .Funct(funct),
    .MulExt(mulext), .A(a_in), .B(b_in), .out_valid(ov0), .out_ready(out_ready),
    .Operation(op0), .Result(res0), .Zero(z0), .Illegal(il0)
  );

  alu_exec_unit #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .ALUOp(aluop), .Funct(funct),
    .MulExt(mulext), .A(a_in[7:0]), .B(b_in[7:0]), .out_valid(ov1), .out_ready(out_ready),
    .Operation(op1), .Result(res1), .Zero(z1), .Illegal(il1)
  );

  alu_exec_unit #(.WIDTH(8), .MUL_EN(1'b0)) dut8n (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .ALUOp(aluop), .Funct(funct),
    .MulExt(mulext), .A(a_in[7:0]), .B(b_in[7:0]), .out_valid(ov2), .out_ready(out_ready),
    .Operation(op2), .Result(res2), .Zero(z2), .Illegal(il2)
  );

  always_comb begin
    c_ir = ir2; c_ov = ov2; c_op = op2; c_res = {56'd0, res2}; c_z = z2; c_il = il2;
    if (sel == 0) begin
      c_ir = ir0; c_ov = ov0; c_op = op0; c_res = res0; c_z = z0; c_il = il0;
    end else if (sel == 1) begin
      c_ir = ir1; c_ov = ov1; c_op = op1; c_res = {56'd0, res1}; c_z = z1; c_il = il1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s (sel %0d): got %h, expected %h", name, sel, act, exp);
    else passed++;
  endtask

  function automatic vec_t mkv(input int s, input logic [1:0] al, input logic [3:0] f,
                               input logic m, input logic [63:0] a, input logic [63:0] b,
                               input logic [3:0] eop, input logic [63:0] eres, input logic eill);
    vec_t v;
    v.sel = s; v.aluop = al; v.funct = f; v.mulext = m; v.a = a; v.b = b;
    v.op = eop; v.res = eres; v.ill = eill;
    return v;
  endfunction

  function automatic exp_t mke(input logic [3:0] op, input logic [63:0] res, input logic ill);
    exp_t e;
    e.op = op; e.res = res; e.ill = ill;
    return e;
  endfunction

  task automatic drive(input logic [1:0] al, input logic [3:0] f, input logic m,
                       input logic [63:0] a, input logic [63:0] b);
    aluop = al; funct = f; mulext = m; a_in = a; b_in = b; in_valid = 1'b1;
    #1;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, " out_valid"}, c_ov, 1);
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL %s scoreboard: result seen with nothing expected", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " Operation"}, c_op, e.op);
      chk({tag, " Result"}, c_res, e.res);
      chk({tag, " Illegal"}, c_il, e.ill);
      chk({tag, " Zero"}, c_z, e.res == 64'd0);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, " in_ready"}, c_ir, 1);
    chk({tag, " out_valid"}, c_ov, 0);
    chk({tag, " Result"}, c_res, 0);
    chk({tag, " Zero"}, c_z, 1);
    chk({tag, " Operation"}, c_op, 0);
    chk({tag, " Illegal"}, c_il, 0);
  endtask

  task automatic run_mul(input int s, input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] mask;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    sel = s;
    drive(2'b10, 4'b0000, 1'b1, a, b);
    chk("mul accept in_ready", c_ir, 1);
    exp_q.push_back(mke(4'b1010, (a * b) & mask, 1'b0));
    step();
    in_valid = 1'b0;
    for (int k = 0; k < w; k++) begin
      chk("mul busy out_valid", c_ov, 0);
      chk("mul busy in_ready", c_ir, 0);
      // Stray request with corrupted operands must be ignored while busy
      if (k == 3) begin
        in_valid = 1'b1; aluop = 2'b00; a_in = ~a;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    check_out("mul");
    step();
  endtask

  initial begin
    total = 0; passed = 0; sel = 1;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    aluop = 2'b00; funct = 4'b0000; mulext = 1'b0; a_in = '0; b_in = '0;

    // Legacy codes on the 64-bit unit
    vecs.push_back(mkv(0, 2'b10, 4'b0000, 0, 64'd5, 64'd3, 4'b0010, 64'd8, 0));
    vecs.push_back(mkv(0, 2'b10, 4'b1000, 0, 64'd5, 64'd3, 4'b0110, 64'd2, 0));
    vecs.push_back(mkv(0, 2'b10, 4'b0111, 0, 64'd5, 64'd3, 4'b0000, 64'd1, 0));
    vecs.push_back(mkv(0, 2'b10, 4'b0110, 0, 64'd5, 64'd3, 4'b0001, 64'd7, 0));
    vecs.push_back(mkv(0, 2'b01, 4'b0000, 0, 64'd9, 64'd9, 4'b0110, 64'd0, 0));
    vecs.push_back(mkv(0, 2'b10, 4'b0100, 0, 64'd5, 64'd3, 4'b0011, 64'd6, 0));
    vecs.push_back(mkv(0, 2'b11, 4'b1101, 0, 64'h8000_0000_0000_0000, 64'd4, 4'b0111,
                       64'hF800_0000_0000_0000, 0));
    vecs.push_back(mkv(0, 2'b00, 4'b1111, 1, 64'd7, 64'd8, 4'b0010, 64'd15, 0));
    vecs.push_back(mkv(0, 2'b10, 4'b0001, 0, 64'd1, 64'h41, 4'b0100, 64'd2, 0));
    // New ops on the 8-bit unit
    vecs.push_back(mkv(1, 2'b10, 4'b1101, 0, 64'h80, 64'd3, 4'b0111, 64'hF0, 0));
    vecs.push_back(mkv(1, 2'b10, 4'b0010, 0, 64'hFF, 64'd1, 4'b1000, 64'd1, 0));
    vecs.push_back(mkv(1, 2'b10, 4'b0011, 0, 64'hFF, 64'd1, 4'b1001, 64'd0, 0));
    vecs.push_back(mkv(1, 2'b11, 4'b1000, 0, 64'd4, 64'd4, 4'b0010, 64'd8, 0));
    vecs.push_back(mkv(1, 2'b10, 4'b1001, 0, 64'd4, 64'd4, 4'b1111, 64'd0, 1));
    vecs.push_back(mkv(1, 2'b10, 4'b0001, 0, 64'h81, 64'h09, 4'b0100, 64'h02, 0));
    vecs.push_back(mkv(1, 2'b10, 4'b0101, 0, 64'h80, 64'd7, 4'b0101, 64'h01, 0));
    vecs.push_back(mkv(1, 2'b11, 4'b0101, 0, 64'hF0, 64'd4, 4'b0101, 64'h0F, 0));
    vecs.push_back(mkv(1, 2'b11, 4'b0010, 0, 64'h01, 64'hFF, 4'b1000, 64'd0, 0));
    vecs.push_back(mkv(1, 2'b10, 4'b1000, 0, 64'd0, 64'd1, 4'b0110, 64'hFF, 0));
    vecs.push_back(mkv(1, 2'b10, 4'b0000, 0, 64'hFF, 64'd2, 4'b0010, 64'h01, 0));
    vecs.push_back(mkv(1, 2'b10, 4'b0001, 1, 64'd2, 64'd2, 4'b1111, 64'd0, 1));
    vecs.push_back(mkv(1, 2'b10, 4'b1010, 0, 64'd2, 64'd2, 4'b1111, 64'd0, 1));
    vecs.push_back(mkv(1, 2'b01, 4'b0111, 1, 64'd2, 64'd5, 4'b0110, 64'hFD, 0));
    // MUL decodes as illegal when the multiplier is absent
    vecs.push_back(mkv(2, 2'b10, 4'b0000, 1, 64'd3, 64'd5, 4'b1111, 64'd0, 1));
    vecs.push_back(mkv(2, 2'b10, 4'b0000, 0, 64'd3, 64'd5, 4'b0010, 64'd8, 0));

    step();
    step();
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_idle_reset("reset");
    end

    // Back-to-back: each request is accepted while the previous result is checked
    begin
      bit pending;
      pending = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
        if (pending && (vecs[i].sel != vecs[i-1].sel)) begin
          in_valid = 1'b0;
          check_out("vec drain");
          step();
          pending = 1'b0;
        end
        sel = vecs[i].sel;
        drive(vecs[i].aluop, vecs[i].funct, vecs[i].mulext, vecs[i].a, vecs[i].b);
        chk("vec in_ready", c_ir, 1);
        if (pending) check_out("vec");
        exp_q.push_back(mke(vecs[i].op, vecs[i].res, vecs[i].ill));
        step();
        pending = 1'b1;
      end
      in_valid = 1'b0;
      check_out("vec last");
      step();
    end

    run_mul(1, 64'd13, 64'd11, 8);
    run_mul(1, 64'hFF, 64'hFF, 8);
    run_mul(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64);

    // Backpressure: result held, in_valid pulses ignored until out_ready returns
    sel = 1;
    drive(2'b10, 4'b0000, 1'b0, 64'd1, 64'd2);
    exp_q.push_back(mke(4'b0010, 64'd3, 1'b0));
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp out_valid", c_ov, 1);
      chk("bp in_ready", c_ir, 0);
      chk("bp Result", c_res, 64'd3);
      chk("bp Operation", c_op, 4'b0010);
      in_valid = k[0];
      aluop = 2'b10; funct = 4'b0100; a_in = 64'hAA; b_in = 64'h55;
      step();
    end
    out_ready = 1'b1;
    drive(2'b10, 4'b1000, 1'b0, 64'd9, 64'd4);
    chk("bp release in_ready", c_ir, 1);
    check_out("bp held");
    exp_q.push_back(mke(4'b0110, 64'd5, 1'b0));
    step();
    in_valid = 1'b0;
    check_out("bp next");
    step();

    // Reset during MUL iteration 4, then a fresh ADD
    sel = 1;
    drive(2'b10, 4'b0000, 1'b1, 64'd13, 64'd11);
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_reset("mid-mul reset");
    drive(2'b00, 4'b0000, 1'b0, 64'd2, 64'd2);
    exp_q.push_back(mke(4'b0010, 64'd4, 1'b0));
    step();
    in_valid = 1'b0;
    check_out("post-reset add");
    step();

    // A request presented while reset is high is dropped
    reset = 1'b1;
    drive(2'b00, 4'b0000, 1'b0, 64'd6, 64'd1);
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("reset request dropped out_valid", c_ov, 0);
    step();
    chk("reset request dropped out_valid+1", c_ov, 0);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
